// File: rtl/condicionador_botoes.sv
//------------------------------------------------------------------------------
// condicionador_botoes: synchronizes, debounces and validates player buttons
// and the start button. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module condicionador_botoes #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       jogar,
  output logic [3:0] botoes_limpos,
  output logic       jogada,
  output logic       jogar_pulso,
  output logic       invalida,
  output logic [3:0] db_estado
);

  localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  localparam logic [1:0] OCIOSO      = 2'd0;
  localparam logic [1:0] FILTRANDO   = 2'd1;
  localparam logic [1:0] PRESSIONADO = 2'd2;
  localparam logic [1:0] SOLTANDO    = 2'd3;

  logic [3:0]    botoes_meta_q, botoes_sync_q;
  logic          jogar_meta_q, jogar_sync_q;

  logic [1:0]    estado_q, estado_d;
  logic [3:0]    candidato_q, candidato_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    limpos_q, limpos_d;
  logic          jogada_q, jogada_d;
  logic          invalida_q, invalida_d;

  logic          estavel_q, estavel_d;
  logic [CW-1:0] jcnt_q, jcnt_d;
  logic          pulso_q, pulso_d;

  logic          candidato_onehot;

  // Two-flop synchronizers; nothing downstream looks at the raw inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botoes_meta_q <= 4'b0000;
      botoes_sync_q <= 4'b0000;
      jogar_meta_q  <= 1'b0;
      jogar_sync_q  <= 1'b0;
    end else begin
      botoes_meta_q <= botoes;
      botoes_sync_q <= botoes_meta_q;
      jogar_meta_q  <= jogar;
      jogar_sync_q  <= jogar_meta_q;
    end
  end

  assign candidato_onehot = (candidato_q != 4'b0000) &&
                            ((candidato_q & (candidato_q - 4'd1)) == 4'b0000);

  always_comb begin
    estado_d    = estado_q;
    candidato_d = candidato_q;
    cnt_d       = cnt_q;
    limpos_d    = limpos_q;
    jogada_d    = 1'b0;
    invalida_d  = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (botoes_sync_q != 4'b0000) begin
          candidato_d = botoes_sync_q;
          cnt_d       = '0;
          estado_d    = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (botoes_sync_q == 4'b0000) begin
          estado_d = OCIOSO;
        end else if (botoes_sync_q != candidato_q) begin
          candidato_d = botoes_sync_q;
          cnt_d       = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Pattern stable for the full window: accept or reject it once.
          estado_d = PRESSIONADO;
          if (candidato_onehot) begin
            limpos_d = candidato_q;
            jogada_d = 1'b1;
          end else begin
            invalida_d = 1'b1;
          end
        end
      end
      PRESSIONADO: begin
        if (botoes_sync_q == 4'b0000) begin
          cnt_d    = '0;
          estado_d = SOLTANDO;
        end
      end
      SOLTANDO: begin
        if (botoes_sync_q != 4'b0000) begin
          estado_d = PRESSIONADO;
        end else if (cnt_q == CNT_MAX) begin
          estado_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    estavel_d = estavel_q;
    jcnt_d    = jcnt_q;
    pulso_d   = 1'b0;
    if (jogar_sync_q == estavel_q) begin
      jcnt_d = '0;
    end else if (jcnt_q != CNT_MAX) begin
      jcnt_d = jcnt_q + 1'b1;
    end else begin
      estavel_d = jogar_sync_q;
      jcnt_d    = '0;
      pulso_d   = jogar_sync_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      candidato_q <= 4'b0000;
      cnt_q       <= '0;
      limpos_q    <= 4'b0000;
      jogada_q    <= 1'b0;
      invalida_q  <= 1'b0;
      estavel_q   <= 1'b0;
      jcnt_q      <= '0;
      pulso_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      candidato_q <= candidato_d;
      cnt_q       <= cnt_d;
      limpos_q    <= limpos_d;
      jogada_q    <= jogada_d;
      invalida_q  <= invalida_d;
      estavel_q   <= estavel_d;
      jcnt_q      <= jcnt_d;
      pulso_q     <= pulso_d;
    end
  end

  assign botoes_limpos = limpos_q;
  assign jogada        = jogada_q;
  assign invalida      = invalida_q;
  assign jogar_pulso   = pulso_q;
  assign db_estado     = {2'b00, estado_q};

endmodule

`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
// Directed testbench for condicionador_botoes with DEBOUNCE_CICLOS=4.
`default_nettype none

module tb_condicionador_botoes;

  logic       clock;
  logic       reset;
  logic [3:0] botoes;
  logic       jogar;
  logic [3:0] botoes_limpos;
  logic       jogada;
  logic       jogar_pulso;
  logic       invalida;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;

  condicionador_botoes #(.DEBOUNCE_CICLOS(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .botoes        (botoes),
    .jogar         (jogar),
    .botoes_limpos (botoes_limpos),
    .jogada        (jogada),
    .jogar_pulso   (jogar_pulso),
    .invalida      (invalida),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go_idle();
    botoes = 4'b0000;
    jogar  = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    botoes = 4'b0000;
    jogar  = 1'b0;
    repeat (3) tick();
    total++; if (botoes_limpos !== 4'b0000) begin bad++; $display("FAIL reset_limpos: got %b want 0000", botoes_limpos); end
    total++; if (jogada !== 1'b0) begin bad++; $display("FAIL reset_jogada: got %b want 0", jogada); end
    total++; if (jogar_pulso !== 1'b0) begin bad++; $display("FAIL reset_pulso: got %b want 0", jogar_pulso); end
    total++; if (invalida !== 1'b0) begin bad++; $display("FAIL reset_invalida: got %b want 0", invalida); end
    total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL reset_db: got %0d want 0", db_estado); end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  // Clean press: jogada after edge 7, db_estado 0 -> 1 -> 2.
  task automatic test_press();
    int n_jog = 0;
    int c_jog = 0;
    int n_inv = 0;
    logic [3:0] exp_db;
    botoes = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (jogada) begin n_jog++; c_jog = c; end
      if (invalida) n_inv++;
      exp_db = (c < 3) ? 4'd0 : (c < 7) ? 4'd1 : 4'd2;
      total++; if (db_estado !== exp_db) begin bad++; $display("FAIL press_db c=%0d: got %0d want %0d", c, db_estado, exp_db); end
      if (c == 6) begin
        total++; if (botoes_limpos !== 4'b0000) begin bad++; $display("FAIL press_limpos_early: got %b want 0000", botoes_limpos); end
      end
    end
    total++; if (n_jog !== 1) begin bad++; $display("FAIL press_count: got %0d want 1", n_jog); end
    total++; if (c_jog !== 7) begin bad++; $display("FAIL press_latency: got %0d want 7", c_jog); end
    total++; if (n_inv !== 0) begin bad++; $display("FAIL press_invalida: got %0d want 0", n_inv); end
    total++; if (botoes_limpos !== 4'b0100) begin bad++; $display("FAIL press_limpos: got %b want 0100", botoes_limpos); end
    go_idle();
    total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL press_release_db: got %0d want 0", db_estado); end
  endtask

  task automatic test_bounce();
    int n_jog = 0;
    int c_jog = 0;
    for (int c = 1; c <= 20; c++) begin
      botoes = (c < 7 && (c % 2) == 0) ? 4'b0000 : 4'b0010;
      tick();
      if (jogada) begin n_jog++; c_jog = c; end
      if (c == 12) begin
        total++; if (botoes_limpos !== 4'b0100) begin bad++; $display("FAIL bounce_limpos_early: got %b want 0100", botoes_limpos); end
      end
    end
    total++; if (n_jog !== 1) begin bad++; $display("FAIL bounce_count: got %0d want 1", n_jog); end
    total++; if (c_jog !== 13) begin bad++; $display("FAIL bounce_latency: got %0d want 13", c_jog); end
    total++; if (botoes_limpos !== 4'b0010) begin bad++; $display("FAIL bounce_limpos: got %b want 0010", botoes_limpos); end
    go_idle();
  endtask

  task automatic test_invalid();
    int n_jog = 0;
    int n_inv = 0;
    int c_inv = 0;
    botoes = 4'b0011;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (jogada) n_jog++;
      if (invalida) begin n_inv++; c_inv = c; end
    end
    total++; if (n_inv !== 1) begin bad++; $display("FAIL invalid_count: got %0d want 1", n_inv); end
    total++; if (c_inv !== 7) begin bad++; $display("FAIL invalid_latency: got %0d want 7", c_inv); end
    total++; if (n_jog !== 0) begin bad++; $display("FAIL invalid_jogada: got %0d want 0", n_jog); end
    total++; if (botoes_limpos !== 4'b0010) begin bad++; $display("FAIL invalid_limpos: got %b want 0010", botoes_limpos); end
    total++; if (db_estado !== 4'd2) begin bad++; $display("FAIL invalid_db: got %0d want 2", db_estado); end
    go_idle();
  endtask

  // Re-touch during release must fall back to PRESSIONADO silently.
  task automatic test_retouch();
    int n_jog = 0;
    int n_ev  = 0;
    botoes = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (jogada) n_jog++;
    end
    total++; if (n_jog !== 1) begin bad++; $display("FAIL retouch_first: got %0d want 1", n_jog); end
    total++; if (botoes_limpos !== 4'b0001) begin bad++; $display("FAIL retouch_limpos: got %b want 0001", botoes_limpos); end
    for (int r = 1; r <= 14; r++) begin
      botoes = (r == 4 || r == 5) ? 4'b0001 : 4'b0000;
      tick();
      if (jogada || invalida) n_ev++;
      if (r == 3) begin
        total++; if (db_estado !== 4'd3) begin bad++; $display("FAIL retouch_db_solt: got %0d want 3", db_estado); end
      end
      if (r == 6) begin
        total++; if (db_estado !== 4'd2) begin bad++; $display("FAIL retouch_db_press: got %0d want 2", db_estado); end
      end
      if (r == 11) begin
        total++; if (db_estado !== 4'd3) begin bad++; $display("FAIL retouch_db_solt2: got %0d want 3", db_estado); end
      end
      if (r == 12) begin
        total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL retouch_db_idle: got %0d want 0", db_estado); end
      end
    end
    total++; if (n_ev !== 0) begin bad++; $display("FAIL retouch_events: got %0d want 0", n_ev); end
    go_idle();
  endtask

  task automatic test_jogar();
    int n_pul = 0;
    int c_pul = 0;
    int n_jog = 0;
    int c_jog = 0;
    int n_both = 0;
    for (int c = 1; c <= 24; c++) begin
      jogar  = (c <= 10);
      botoes = (c <= 20) ? 4'b1000 : 4'b0000;
      tick();
      if (jogar_pulso) begin n_pul++; c_pul = c; end
      if (jogada) begin n_jog++; c_jog = c; end
      if (jogada && invalida) n_both++;
    end
    total++; if (n_pul !== 1) begin bad++; $display("FAIL jogar_count: got %0d want 1", n_pul); end
    total++; if (c_pul !== 6) begin bad++; $display("FAIL jogar_latency: got %0d want 6", c_pul); end
    total++; if (n_jog !== 1) begin bad++; $display("FAIL jogar_jogada_count: got %0d want 1", n_jog); end
    total++; if (c_jog !== 7) begin bad++; $display("FAIL jogar_jogada_latency: got %0d want 7", c_jog); end
    total++; if (n_both !== 0) begin bad++; $display("FAIL jogar_overlap: got %0d want 0", n_both); end
    total++; if (botoes_limpos !== 4'b1000) begin bad++; $display("FAIL jogar_limpos: got %b want 1000", botoes_limpos); end
    go_idle();
    // A 2-cycle glitch on jogar is shorter than the debounce window.
    n_pul = 0;
    for (int c = 1; c <= 12; c++) begin
      jogar = (c <= 2);
      tick();
      if (jogar_pulso) n_pul++;
    end
    total++; if (n_pul !== 0) begin bad++; $display("FAIL jogar_glitch: got %0d want 0", n_pul); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    int n_jog = 0;
    int c_jog = 0;
    botoes = 4'b0100;
    repeat (4) tick();
    total++; if (db_estado !== 4'd1) begin bad++; $display("FAIL rmid_db_before: got %0d want 1", db_estado); end
    #2 reset = 1'b1;
    #1;
    total++; if (botoes_limpos !== 4'b0000) begin bad++; $display("FAIL rmid_limpos: got %b want 0000", botoes_limpos); end
    total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL rmid_db: got %0d want 0", db_estado); end
    total++; if ({jogada, jogar_pulso, invalida} !== 3'b000) begin bad++; $display("FAIL rmid_pulses: got %b want 000", {jogada, jogar_pulso, invalida}); end
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (jogada) begin n_jog++; c_jog = c; end
      if (c == 2) begin
        total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL rmid_db_sync: got %0d want 0", db_estado); end
      end
    end
    total++; if (n_jog !== 1) begin bad++; $display("FAIL rmid_count: got %0d want 1", n_jog); end
    total++; if (c_jog !== 7) begin bad++; $display("FAIL rmid_latency: got %0d want 7", c_jog); end
    total++; if (botoes_limpos !== 4'b0100) begin bad++; $display("FAIL rmid_limpos_after: got %b want 0100", botoes_limpos); end
    go_idle();
  endtask

  initial begin
    reset  = 1'b1;
    botoes = 4'b0000;
    jogar  = 1'b0;
    test_reset();
    test_press();
    test_bounce();
    test_invalid();
    test_retouch();
    test_jogar();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 Parameter: DEBOUNCE_CICLOS, default 50000, number of consecutive stable clock cycles required to accept an input level; legal range 2 to 2^20.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 botoes  input  4  raw player buttons, active-high, asynchronous to clock.
REQ-005 jogar  input  1  raw start button, active-high, asynchronous to clock.
REQ-006 botoes_limpos  output  4  registered one-hot code of the last accepted press; held until the next accepted press.
REQ-007 jogada  output  1  one-cycle pulse marking an accepted one-hot press; feeds the game's botoes/jogada-feita path.
REQ-008 jogar_pulso  output  1  one-cycle pulse on the debounced rising edge of jogar.
REQ-009 invalida  output  1  one-cycle pulse when a stable non-one-hot pattern (2+ buttons) is filtered.
REQ-010 db_estado  output  4  encoded FSM state for the hexa7seg display.

Function
REQ-011 botoes and jogar SHALL each pass through a 2-flop synchronizer; all further logic SHALL use only synchronized values (S).
REQ-012 Button FSM states and codes: OCIOSO=0, FILTRANDO=1, PRESSIONADO=2, SOLTANDO=3; db_estado SHALL equal the current code, upper bits 0.
REQ-013 OCIOSO: on S!=0, load candidate<=S, counter<=0, go FILTRANDO; otherwise stay.
REQ-014 FILTRANDO: S==0 -> OCIOSO; S!=0 and S!=candidate -> candidate<=S, counter<=0, stay; S==candidate and counter<DEBOUNCE_CICLOS-1 -> counter+1.
REQ-015 FILTRANDO with S==candidate and counter==DEBOUNCE_CICLOS-1: go PRESSIONADO; if candidate is one-hot, botoes_limpos<=candidate and jogada=1 for that one cycle; otherwise invalida=1 for one cycle and botoes_limpos unchanged.
REQ-016 PRESSIONADO: S==0 -> counter<=0, go SOLTANDO; otherwise stay (holding or adding buttons creates no new event).
REQ-017 SOLTANDO: S!=0 -> PRESSIONADO; S==0 and counter==DEBOUNCE_CICLOS-1 -> OCIOSO; otherwise counter+1.
REQ-018 Press latency: for a clean press on a quiet input, jogada SHALL be high in exactly the cycle after rising edge DEBOUNCE_CICLOS+3, counted from the first rising edge that samples the new raw value.
REQ-019 At most one jogada or invalida pulse per press-release cycle; jogada and invalida SHALL never be high together.
REQ-020 Counter width SHALL be ceil(log2(DEBOUNCE_CICLOS)); the counter SHALL never wrap.
REQ-021 jogar path: stable level E and counter C; S==E -> C<=0; S!=E and C<DEBOUNCE_CICLOS-1 -> C+1; S!=E and C==DEBOUNCE_CICLOS-1 -> E<=S, C<=0.
REQ-022 jogar_pulso SHALL be 1 for exactly the one cycle after E changes 0->1; the jogar and button paths are independent and may pulse in the same cycle.
REQ-023 Bounces (a level change shorter than DEBOUNCE_CICLOS cycles) SHALL produce no pulse on any output.

Reset
REQ-024 reset high SHALL immediately force: synchronizers 0, FSM OCIOSO, counters 0, candidate 0, E 0, botoes_limpos 0000, jogada 0, jogar_pulso 0, invalida 0, db_estado 0000.
REQ-025 Reset asserted mid-filter or mid-press SHALL discard the event; after release, a button still held SHALL be filtered as a new press.

Verification (DEBOUNCE_CICLOS=4)
REQ-026 botoes 0000->0100 held 20 cycles -> jogada high exactly one cycle, after edge 7; botoes_limpos=0100; db_estado sequence 0,1,2.
REQ-027 botoes 0010 bounced 1-cycle high/low x3, then held -> a single jogada only after the final stable window; botoes_limpos=0010.
REQ-028 botoes 0011 held 20 cycles -> invalida one pulse, jogada never, botoes_limpos keeps its previous value.
REQ-029 0001 held then released with a 2-cycle re-touch inside SOLTANDO -> returns to PRESSIONADO and produces no second jogada; full release -> OCIOSO.
REQ-030 jogar held 10 cycles -> exactly one jogar_pulso; a simultaneous botoes 1000 press -> both jogar_pulso and jogada, each exactly once.
REQ-031 reset pulsed while db_estado=1 -> all outputs 0 immediately; button still held -> new jogada DEBOUNCE_CICLOS+3 edges after reset release.
